tb_irq_timer: RTL and testbench

Memory-mapped interrupt source for the core testbench subsystem. It sits on the pseudo-peripheral data path decoded by the testbench RAM model and drives the core's software, timer, external and fast interrupt lines. It consumes the core's interrupt acknowledge (`irq_ack`, `irq_id`) so that tests can raise, observe and retire interrupts deterministically. It contains a prescaled 64-bit `mtime` counter with a 64-bit compare register, a software-interrupt bit, an external-interrupt bit and a 16-bit fast-interrupt pending register.

---
 rtl/tb_irq_timer.sv | 210 +++++++++++++++++++++
 tb/tb_tb_irq_timer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_irq_timer
//   Memory-mapped interrupt source for the core testbench subsystem. Holds a
//   prescaled 64-bit mtime counter with a 64-bit compare register, a
//   software-interrupt bit (MSIP), an external-interrupt bit (EXTIP) and a
//   16-bit fast-interrupt pending register. The core's acknowledge retires
//   MSIP, EXTIP and the fast pending bits.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i               request (already qualified by the address decode)
//   addr_i              byte address; offset is addr_i[5:0]
//   we_i, be_i, wdata_i write enable, byte enables, write data
//   gnt_o               grant (combinational copy of req_i)
//   rvalid_o, rdata_o   response valid / registered read data
//   irq_id_i, irq_ack_i interrupt acknowledge from the core
//   irq_software_o      MSIP bit 0
//   irq_timer_o         registered (mtime >= mtimecmp)
//   irq_external_o      EXTIP bit 0
//   irq_fast_o          FAST_PEND
//
// Handshake: a request is granted in the cycle req_i is high (gnt_o = req_i).
// Exactly one cycle later rvalid_o pulses for that request, reads and writes
// alike, so back-to-back requests yield back-to-back rvalid_o pulses. rdata_o
// carries the register value seen at the grant edge for reads, 0 otherwise.
// ---------------------------------------------------------------------------
module tb_irq_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'h1500_0000,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic [4:0]  irq_id_i,
  input  logic        irq_ack_i,
  output logic        irq_software_o,
  output logic        irq_timer_o,
  output logic        irq_external_o,
  output logic [15:0] irq_fast_o
);

  localparam logic [5:0] OFF_MTIME_LO = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI = 6'h04;
  localparam logic [5:0] OFF_CMP_LO   = 6'h08;
  localparam logic [5:0] OFF_CMP_HI   = 6'h0C;
  localparam logic [5:0] OFF_PRESCALE = 6'h10;
  localparam logic [5:0] OFF_MSIP     = 6'h14;
  localparam logic [5:0] OFF_EXTIP    = 6'h18;
  localparam logic [5:0] OFF_FAST_SET = 6'h1C;
  localparam logic [5:0] OFF_FAST_PND = 6'h20;

  localparam logic [4:0] ID_SOFTWARE = 5'd3;
  localparam logic [4:0] ID_EXTERNAL = 5'd11;

  // State
  logic [63:0]               mtime_q,    mtime_d;
  logic [63:0]               mtimecmp_q, mtimecmp_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q,     pcnt_d;
  logic                      msip_q,     msip_d;
  logic                      extip_q,    extip_d;
  logic [15:0]               fast_q,     fast_d;
  logic                      timer_q,    timer_d;
  logic                      rvalid_q,   rvalid_d;
  logic [31:0]               rdata_q,    rdata_d;

  // Byte-lane merge of a 32-bit write into an existing 32-bit value.
  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode. The upper address bits are matched against the window
  // so that a stray access outside it behaves like an unmapped offset.
  logic       in_win;
  logic [5:0] off;
  logic       wr_en;
  logic [15:0] fast_mask;

  assign in_win    = (addr_i[31:6] == BASE_ADDR[31:6]);
  assign off       = addr_i[5:0];
  assign wr_en     = req_i & we_i & in_win;
  assign fast_mask = wdata_i[15:0] & {{8{be_i[1]}}, {8{be_i[0]}}};

  // Next-state logic for the timer block and the interrupt sources.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    msip_d     = msip_q;
    extip_d    = extip_q;
    fast_d     = fast_q;

    // Free-running prescaler: mtime advances once per (PRESCALE+1) cycles.
    if (pcnt_q == prescale_q) begin
      pcnt_d  = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      pcnt_d  = pcnt_q + 1'b1;
    end

    // Software writes to mtime replace that cycle's increment.
    if (wr_en && off == OFF_MTIME_LO) begin
      mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata_i, be_i)};
      pcnt_d  = '0;
    end
    if (wr_en && off == OFF_MTIME_HI) begin
      mtime_d = {merge_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
      pcnt_d  = '0;
    end
    if (wr_en && off == OFF_CMP_LO) begin
      mtimecmp_d[31:0] = merge_be(mtimecmp_q[31:0], wdata_i, be_i);
    end
    if (wr_en && off == OFF_CMP_HI) begin
      mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wdata_i, be_i);
    end
    if (wr_en && off == OFF_PRESCALE) begin
      prescale_d = PRESCALE_WIDTH'(merge_be(32'(prescale_q), wdata_i, be_i));
      pcnt_d     = '0;
    end

    // Clears first, then sets, so a write in the same cycle wins.
    if (irq_ack_i && irq_id_i == ID_SOFTWARE) msip_d  = 1'b0;
    if (irq_ack_i && irq_id_i == ID_EXTERNAL) extip_d = 1'b0;
    if (irq_ack_i && irq_id_i[4])             fast_d[irq_id_i[3:0]] = 1'b0;
    if (wr_en && off == OFF_FAST_PND)         fast_d = fast_d & ~fast_mask;

    if (wr_en && off == OFF_MSIP  && be_i[0]) msip_d  = wdata_i[0];
    if (wr_en && off == OFF_EXTIP && be_i[0]) extip_d = wdata_i[0];
    if (wr_en && off == OFF_FAST_SET)         fast_d = fast_d | fast_mask;
  end

  // Compare uses the current register values, giving one cycle of latency.
  assign timer_d = (mtime_q >= mtimecmp_q);

  // Read path: value of the addressed register before this edge's update.
  logic [31:0] prescale_rd;
  logic [31:0] rd_val;

  always_comb begin
    prescale_rd = '0;
    prescale_rd[PRESCALE_WIDTH-1:0] = prescale_q;
    rd_val = '0;
    if (in_win) begin
      case (off)
        OFF_MTIME_LO: rd_val = mtime_q[31:0];
        OFF_MTIME_HI: rd_val = mtime_q[63:32];
        OFF_CMP_LO:   rd_val = mtimecmp_q[31:0];
        OFF_CMP_HI:   rd_val = mtimecmp_q[63:32];
        OFF_PRESCALE: rd_val = prescale_rd;
        OFF_MSIP:     rd_val = {31'd0, msip_q};
        OFF_EXTIP:    rd_val = {31'd0, extip_q};
        OFF_FAST_PND: rd_val = {16'd0, fast_q};
        default:      rd_val = '0;
      endcase
    end
  end

  assign rvalid_d = req_i;
  assign rdata_d  = (req_i && !we_i) ? rd_val : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      prescale_q <= '0;
      pcnt_q     <= '0;
      msip_q     <= 1'b0;
      extip_q    <= 1'b0;
      fast_q     <= '0;
      timer_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      msip_q     <= msip_d;
      extip_q    <= extip_d;
      fast_q     <= fast_d;
      timer_q    <= timer_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt_o          = req_i;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign irq_software_o = msip_q;
  assign irq_timer_o    = timer_q;
  assign irq_external_o = extip_q;
  assign irq_fast_o     = fast_q;

endmodule

// File: tb/tb_tb_irq_timer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for tb_irq_timer: directed scenarios with literal
// expectations followed by randomized bus/acknowledge traffic, all checked
// every cycle against a behavioural model of the register block.
// ---------------------------------------------------------------------------
module tb_tb_irq_timer;

  localparam logic [31:0] BASE = 32'h1500_0000;
  localparam int          PW   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        req = 1'b0, we = 1'b0, irq_ack = 1'b0;
  logic [31:0] addr = BASE, wdata = '0;
  logic [3:0]  be = '0;
  logic [4:0]  irq_id = '0;
  logic        gnt, rvalid, irq_sw, irq_tmr, irq_ext;
  logic [31:0] rdata;
  logic [15:0] irq_fast;

  tb_irq_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .irq_id_i(irq_id), .irq_ack_i(irq_ack),
    .irq_software_o(irq_sw), .irq_timer_o(irq_tmr),
    .irq_external_o(irq_ext), .irq_fast_o(irq_fast)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime, m_cmp;
  int unsigned m_pre, m_pcnt;
  bit          m_msip, m_extip, m_timer;
  logic [15:0] m_fast;
  bit          exp_rvalid;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] o);
    case (o)
      6'h00: return m_mtime[31:0];
      6'h04: return m_mtime[63:32];
      6'h08: return m_cmp[31:0];
      6'h0C: return m_cmp[63:32];
      6'h10: return m_pre;
      6'h14: return {31'd0, m_msip};
      6'h18: return {31'd0, m_extip};
      6'h20: return {16'd0, m_fast};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_pre = 0; m_pcnt = 0;
    m_msip = 0; m_extip = 0; m_fast = '0; m_timer = 0;
    exp_rvalid = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [63:0] n_mtime, n_cmp;
    int unsigned n_pre, n_pcnt;
    bit          n_msip, n_extip;
    logic [15:0] n_fast, bits;
    logic [5:0]  o;
    o = addr[5:0];
    // response for this cycle's request appears next cycle
    exp_rvalid = req;
    if (req) exp_q.push_back(we ? 32'd0 : m_read(o));
    // irq_timer is last cycle's compare result
    m_timer = (m_mtime >= m_cmp);
    // one mtime tick every (PRESCALE+1) cycles
    if (m_pcnt == m_pre) begin n_mtime = m_mtime + 1; n_pcnt = 0; end
    else begin n_mtime = m_mtime; n_pcnt = m_pcnt + 1; end
    n_cmp = m_cmp; n_pre = m_pre;
    n_msip = m_msip; n_extip = m_extip; n_fast = m_fast;
    bits = wdata[15:0] & {{8{be[1]}}, {8{be[0]}}};
    if (irq_ack) begin
      if (irq_id == 5'd3)  n_msip = 0;
      if (irq_id == 5'd11) n_extip = 0;
      if (irq_id >= 5'd16) n_fast[irq_id - 5'd16] = 1'b0;
    end
    if (req && we) begin
      case (o)
        6'h00: begin n_mtime = {m_mtime[63:32], bmerge(m_mtime[31:0], wdata, be)}; n_pcnt = 0; end
        6'h04: begin n_mtime = {bmerge(m_mtime[63:32], wdata, be), m_mtime[31:0]}; n_pcnt = 0; end
        6'h08: n_cmp = {m_cmp[63:32], bmerge(m_cmp[31:0], wdata, be)};
        6'h0C: n_cmp = {bmerge(m_cmp[63:32], wdata, be), m_cmp[31:0]};
        6'h10: begin n_pre = bmerge(m_pre, wdata, be) % (1 << PW); n_pcnt = 0; end
        6'h14: if (be[0]) n_msip = wdata[0];
        6'h18: if (be[0]) n_extip = wdata[0];
        6'h1C: n_fast = n_fast | bits;
        6'h20: n_fast = n_fast & ~bits;
        default: ;
      endcase
    end
    m_mtime = n_mtime; m_cmp = n_cmp; m_pre = n_pre; m_pcnt = n_pcnt;
    m_msip = n_msip; m_extip = n_extip; m_fast = n_fast;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("gnt", gnt, req);
    chk("rvalid", rvalid, exp_rvalid);
    if (exp_rvalid) begin
      if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
      else                   chk("rdata", rdata, exp_q.pop_front());
    end else begin
      chk("rdata_idle", rdata, 0);
    end
    chk("irq_timer", irq_tmr, m_timer);
    chk("irq_software", irq_sw, m_msip);
    chk("irq_external", irq_ext, m_extip);
    chk("irq_fast", irq_fast, m_fast);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge; one call = one cycle.
  task automatic drive(input bit r, input bit w, input logic [5:0] o, input logic [3:0] b,
                       input logic [31:0] d, input bit a, input logic [4:0] id);
    req = r; we = w; addr = BASE + {26'd0, o}; be = b; wdata = d;
    irq_ack = a; irq_id = id;
    @(posedge clk); #2;
    req = 0; we = 0; be = '0; wdata = '0; irq_ack = 0; irq_id = '0; addr = BASE;
  endtask

  task automatic wr(input logic [5:0] o, input logic [31:0] d);
    drive(1, 1, o, 4'hF, d, 0, 5'd0);
  endtask

  task automatic rd(input logic [5:0] o, output logic [31:0] d);
    drive(1, 0, o, 4'h0, 32'd0, 0, 5'd0);
    d = rdata;
  endtask

  task automatic ack(input logic [4:0] id);
    drive(0, 0, 6'h0, 4'h0, 32'd0, 1, id);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 6'h0, 4'h0, 32'd0, 0, 5'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // reset state
    chk("reset_irq_fast", irq_fast, 16'h0);
    chk("reset_rvalid", rvalid, 0);
    rd(6'h00, d); chk("reset_mtime_lo", d, 32'h0);
    rd(6'h08, d); chk("reset_cmp_lo", d, 32'hFFFF_FFFF);
    rd(6'h0C, d); chk("reset_cmp_hi", d, 32'hFFFF_FFFF);
    rd(6'h10, d); chk("reset_prescale", d, 32'h0);

    // timer compare with PRESCALE = 3
    wr(6'h10, 32'd3);
    wr(6'h0C, 32'd0);
    wr(6'h08, 32'd10);
    wr(6'h04, 32'd0);
    wr(6'h00, 32'd0);
    rd(6'h00, d); chk("tc_mtime_start", d, 32'd0);
    idle(39);     chk("tc_timer_before", irq_tmr, 0);
    idle(1);      chk("tc_timer_rise", irq_tmr, 1);
    rd(6'h00, d); chk("tc_mtime_ten", d, 32'd10);
    wr(6'h08, 32'hFFFF_FFFF); chk("tc_timer_hold", irq_tmr, 1);
    idle(1);      chk("tc_timer_drop", irq_tmr, 0);

    // counter wrap
    wr(6'h0C, 32'hFFFF_FFFF);
    wr(6'h10, 32'd0);
    wr(6'h04, 32'hFFFF_FFFF);
    wr(6'h00, 32'hFFFF_FFFE);
    rd(6'h00, d); chk("wrap_lo_fffe", d, 32'hFFFF_FFFE);
    rd(6'h04, d); chk("wrap_hi_ones", d, 32'hFFFF_FFFF);
    rd(6'h00, d); chk("wrap_lo_zero", d, 32'h0);
    rd(6'h04, d); chk("wrap_hi_zero", d, 32'h0);

    // fast set / ack / collision / W1C
    wr(6'h1C, 32'h0000_8001);              chk("fast_set", irq_fast, 16'h8001);
    ack(5'd31);                            chk("fast_ack31", irq_fast, 16'h0001);
    drive(1, 1, 6'h1C, 4'hF, 32'h4, 1, 5'd18);
    chk("fast_collision", irq_fast, 16'h0005);
    wr(6'h20, 32'h4);                      chk("fast_w1c", irq_fast, 16'h0001);
    rd(6'h1C, d);                          chk("fast_set_reads0", d, 32'h0);
    wr(6'h20, 32'h1);                      chk("fast_w1c_all", irq_fast, 16'h0);

    // MSIP / EXTIP
    wr(6'h14, 32'h1);
    wr(6'h18, 32'h1);
    chk("msip_set", irq_sw, 1); chk("extip_set", irq_ext, 1);
    ack(5'd3);  chk("ack3_sw", irq_sw, 0); chk("ack3_ext", irq_ext, 1);
    ack(5'd7);  chk("ack7_sw", irq_sw, 0); chk("ack7_ext", irq_ext, 1);
    ack(5'd11); chk("ack11_ext", irq_ext, 0);

    // unmapped back-to-back
    rd(6'h3C, d);               chk("b2b_rv0", rvalid, 1); chk("b2b_rd0", d, 0);
    wr(6'h3C, $urandom());      chk("b2b_rv1", rvalid, 1); chk("b2b_rd1", rdata, 0);
    rd(6'h3C, d);               chk("b2b_rv2", rvalid, 1); chk("b2b_rd2", d, 0);

    // asynchronous reset mid-transaction
    wr(6'h14, 32'h1);
    wr(6'h1C, 32'hFFFF);
    wr(6'h08, 32'h0);
    wr(6'h0C, 32'h0);
    rd(6'h14, d); chk("pre_rst_rd", d, 32'h1);
    #1 rst = 1;
    #1;
    chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_sw", irq_sw, 0);     chk("rst_ext", irq_ext, 0);
    chk("rst_tmr", irq_tmr, 0);   chk("rst_fast", irq_fast, 0);
    @(posedge clk); #2 rst = 0;
    rd(6'h08, d); chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(6'h0C, d); chk("rst_cmp_hi", d, 32'hFFFF_FFFF);

    // randomized traffic
    for (int it = 0; it < 4000; it++) begin
      bit          r, w, a;
      logic [5:0]  o;
      logic [3:0]  b;
      logic [31:0] dd;
      logic [4:0]  id;
      if ($urandom_range(0, 799) == 0) begin
        rst = 1; @(posedge clk); #2 rst = 0;
      end
      r  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1);
      o  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(9, 15) * 4)
                                       : 6'($urandom_range(0, 8) * 4);
      b  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      dd = $urandom();
      if (o == 6'h04 || o == 6'h0C) dd = ($urandom_range(0, 3) == 0) ? dd : 32'd0;
      if (o == 6'h00 || o == 6'h08) dd = ($urandom_range(0, 1) == 0) ? dd : 32'($urandom_range(0, 60));
      if (o == 6'h10) dd = ($urandom_range(0, 3) == 0) ? dd : 32'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: id = 5'd3;
        1: id = 5'd11;
        2: id = 5'($urandom_range(16, 31));
        default: id = 5'($urandom_range(0, 31));
      endcase
      drive(r, w, o, b, dd, a, id);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
